// File: rtl/mem_fwd_ctrl.sv
// -----------------------------------------------------------------------------
// mem_fwd_ctrl
// M-stage load controller. Issues a word-aligned data-memory read for each load
// instruction, freezes the pipeline while the read is outstanding, extracts and
// extends the requested byte/halfword/word, and presents the result for one
// cycle for X-stage forwarding and writeback. A load that waits too long for
// read data is aborted with an error pulse.
//
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles allowed before a load is aborted (2..255)
//
// Configuration macro
//   MISALIGN_TRAP_EN : when defined, a misaligned LH/LHU/LW raises load_err and
//                      is not issued. When undefined, the low address bits that
//                      do not belong to the access size are simply ignored.
//
// Ports
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   m_valid     : new instruction in M this cycle (one pulse per instruction)
//   inst_M      : M-stage instruction (opcode [6:0], rd [11:7], funct3 [14:12])
//   addr_M      : effective load address
//   dmem_req    : data-memory read request (combinational, request cycle only)
//   dmem_addr   : word-aligned request address
//   dmem_rvalid : read data valid
//   dmem_rdata  : raw read word
//   stall       : freezes IF/X/M pipeline registers (combinational)
//   fwd_valid   : fwd_rd/fwd_data valid for forwarding and writeback
//   fwd_rd      : destination register of the completed load
//   fwd_data    : extracted, extended load result
//   load_err    : one-cycle pulse on timeout or misalignment trap
// -----------------------------------------------------------------------------
module mem_fwd_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        m_valid,
   input  logic [31:0] inst_M,
   input  logic [31:0] addr_M,
   output logic        dmem_req,
   output logic [31:0] dmem_addr,
   input  logic        dmem_rvalid,
   input  logic [31:0] dmem_rdata,
   output logic        stall,
   output logic        fwd_valid,
   output logic [4:0]  fwd_rd,
   output logic [31:0] fwd_data,
   output logic        load_err
);

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT_CYCLES - 1);

   localparam logic [2:0] F3_LB      = 3'd0;
   localparam logic [2:0] F3_LH      = 3'd1;
   localparam logic [2:0] F3_LW      = 3'd2;
   localparam logic [2:0] F3_LBU     = 3'd4;
   localparam logic [2:0] F3_LHU     = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WAIT = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t      state_r;
   state_t      stateNext_s;
   logic [7:0]  waitCnt_r;
   logic [4:0]  rd_r;
   logic [2:0]  funct3_r;
   logic [1:0]  offset_r;
   logic        fwdValid_r;
   logic [4:0]  fwdRd_r;
   logic [31:0] fwdData_r;
   logic        loadErr_r;

   logic        isLoad_s;
   logic        misalign_s;
   logic        accept_s;
   logic        trap_s;
   logic        timeout_s;
   logic        take_s;
   logic        dmemReq_s;
   logic        stall_s;
   logic        unusedInst_s;

   // Select and extend the loaded value from the raw word; reserved funct3
   // encodings produce zero rather than a guessed width.
   function automatic logic [31:0] extractLoad(
      input logic [31:0] word,
      input logic [2:0]  f3,
      input logic [1:0]  off
   );
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] res;
      case (off)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         2'd3:    b = word[31:24];
         default: b = 8'd0;
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (f3)
         F3_LB:   res = {{24{b[7]}}, b};
         F3_LH:   res = {{16{h[15]}}, h};
         F3_LW:   res = word;
         F3_LBU:  res = {24'd0, b};
         F3_LHU:  res = {16'd0, h};
         default: res = 32'd0;
      endcase
      return res;
   endfunction

   assign isLoad_s = m_valid && (inst_M[6:0] == OPC_LOAD);

`ifdef MISALIGN_TRAP_EN
   assign misalign_s = isLoad_s &&
                       ((((inst_M[14:12] == F3_LH) || (inst_M[14:12] == F3_LHU)) && addr_M[0]) ||
                        ((inst_M[14:12] == F3_LW) && (addr_M[1:0] != 2'b00)));
`else
   assign misalign_s = 1'b0;
`endif

   assign accept_s  = (state_r == IDLE) && isLoad_s && !misalign_s;
   assign trap_s    = (state_r == IDLE) && misalign_s;
   assign take_s    = (state_r == WAIT) && dmem_rvalid;
   // The last permitted WAIT cycle still accepts rvalid; only its absence times out.
   assign timeout_s = (state_r == WAIT) && !dmem_rvalid && (waitCnt_r == CNT_LAST);

   // Upper instruction bits are not needed by this stage.
   assign unusedInst_s = ^inst_M[31:15];

   // Next-state and combinational request/stall decode.
   always_comb begin
      stateNext_s = state_r;
      dmemReq_s   = 1'b0;
      stall_s     = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               dmemReq_s   = 1'b1;
               stall_s     = 1'b1;
               stateNext_s = WAIT;
            end else begin
               stateNext_s = IDLE;
            end
         end
         WAIT: begin
            stall_s = !dmem_rvalid;
            if (dmem_rvalid) begin
               stateNext_s = DONE;
            end else if (timeout_s) begin
               stateNext_s = IDLE;
            end else begin
               stateNext_s = WAIT;
            end
         end
         DONE: begin
            stateNext_s = IDLE;
         end
         default: begin
            stateNext_s = IDLE;
         end
      endcase
   end

   // rst_n gating keeps request and stall low even while reset is held with a
   // load presented on the inputs.
   assign dmem_req  = dmemReq_s & rst_n;
   assign stall     = stall_s & rst_n;
   assign dmem_addr = {addr_M[31:2], 2'b00};

   assign fwd_valid = fwdValid_r;
   assign fwd_rd    = fwdRd_r;
   assign fwd_data  = fwdData_r;
   assign load_err  = loadErr_r;

   // State register, transaction latches, wait counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         waitCnt_r  <= 8'd0;
         rd_r       <= 5'd0;
         funct3_r   <= 3'd0;
         offset_r   <= 2'd0;
         fwdValid_r <= 1'b0;
         fwdRd_r    <= 5'd0;
         fwdData_r  <= 32'd0;
         loadErr_r  <= 1'b0;
      end else begin
         state_r   <= stateNext_s;
         loadErr_r <= trap_s || timeout_s;

         if (accept_s) begin
            rd_r     <= inst_M[11:7];
            funct3_r <= inst_M[14:12];
            offset_r <= addr_M[1:0];
         end

         if (accept_s || timeout_s) begin
            waitCnt_r <= 8'd0;
         end else if ((state_r == WAIT) && !dmem_rvalid) begin
            waitCnt_r <= waitCnt_r + 8'd1;
         end

         // A load to x0 completes silently: nothing is forwarded and the
         // previous forwarding value stays on fwd_rd/fwd_data.
         fwdValid_r <= take_s && (rd_r != 5'd0);
         if (take_s && (rd_r != 5'd0)) begin
            fwdRd_r   <= rd_r;
            fwdData_r <= extractLoad(dmem_rdata, funct3_r, offset_r);
         end
      end
   end

endmodule

// File: tb/tb_mem_fwd_ctrl.sv
module tb_mem_fwd_ctrl;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        m_valid;
   logic [31:0] inst_M;
   logic [31:0] addr_M;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        stall;
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
   logic        load_err;

   int nChecks = 0;
   int nFails  = 0;

   // reference state: last forwarded value
   logic [31:0] lastData;
   logic [4:0]  lastRd;

   // observations collected by runLoad
   int          obsReq, obsStall, obsFwdCnt, obsFwdCycle, obsErrCnt, obsErrCycle;
   logic [31:0] obsAddr, obsFwdData, obsFinalData;
   logic [4:0]  obsFwdRd, obsFinalRd;

   always #5 clk = ~clk;

   mem_fwd_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst_n(rst_n), .m_valid(m_valid), .inst_M(inst_M), .addr_M(addr_M),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_rvalid(dmem_rvalid),
      .dmem_rdata(dmem_rdata), .stall(stall), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
      .fwd_data(fwd_data), .load_err(load_err)
   );

   // Reference: load result by arithmetic on the word
   function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] word);
      int unsigned off;
      logic [31:0] v;
      off = addr % 4;
      case (f3)
         3'd0: begin v = (word >> (8 * off)) % 256;         return (v >= 128) ? v + 32'hFFFFFF00 : v; end
         3'd1: begin v = (word >> (16 * (off / 2))) % 65536; return (v >= 32768) ? v + 32'hFFFF0000 : v; end
         3'd2: return word;
         3'd4: begin v = (word >> (8 * off)) % 256;          return v; end
         3'd5: begin v = (word >> (16 * (off / 2))) % 65536; return v; end
         default: return 32'd0;
      endcase
   endfunction

   // Drive one load; rvalid arrives after 'delay' WAIT cycles without it.
   task automatic runLoad(input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] addr,
                          input int delay, input logic [31:0] data, input logic extraRv);
      int total;
      total = ((delay > TO) ? delay : TO) + 5;
      obsReq = 0; obsStall = 0; obsFwdCnt = 0; obsFwdCycle = -1; obsErrCnt = 0; obsErrCycle = -1;
      obsAddr = 32'd0; obsFwdData = 32'd0; obsFwdRd = 5'd0;
      for (int c = 0; c < total; c++) begin
         @(negedge clk);
         m_valid     = (c == 0);
         inst_M      = (c == 0) ? {17'd0, f3, rd, 7'b0000011} : 32'd0;
         addr_M      = addr;
         dmem_rvalid = (c == delay + 1) || (extraRv && (c == delay + 2));
         dmem_rdata  = (c == delay + 1) ? data : $urandom();
         #1;
         if (dmem_req) begin obsReq++; obsAddr = dmem_addr; end
         if (stall) obsStall++;
         if (fwd_valid) begin obsFwdCnt++; obsFwdCycle = c; obsFwdRd = fwd_rd; obsFwdData = fwd_data; end
         if (load_err) begin obsErrCnt++; obsErrCycle = c; end
      end
      obsFinalData = fwd_data;
      obsFinalRd   = fwd_rd;
      m_valid = 1'b0; dmem_rvalid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; m_valid = 1'b1; inst_M = {17'd0, 3'd2, 5'd3, 7'b0000011};
      addr_M = 32'h0000_0040; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
      repeat (2) @(negedge clk);
      #1;
      nChecks++; if (dmem_req !== 1'b0) begin nFails++; $display("FAIL reset_req: got %b expected 0", dmem_req); end
      nChecks++; if (stall !== 1'b0) begin nFails++; $display("FAIL reset_stall: got %b expected 0", stall); end
      nChecks++; if ({fwd_valid, load_err, fwd_rd, fwd_data} !== 39'd0) begin nFails++;
         $display("FAIL reset_outs: got v=%b e=%b rd=%0d d=%h expected all 0", fwd_valid, load_err, fwd_rd, fwd_data); end
      @(negedge clk);
      rst_n = 1'b1; m_valid = 1'b0;
      lastData = 32'd0; lastRd = 5'd0;
      @(negedge clk);
   endtask

   task automatic test_lw_basic();
      runLoad(3'd2, 5'd5, 32'h0000_0100, 3, 32'hDEADBEEF, 1'b0);
      nChecks++; if (obsStall !== 4) begin nFails++; $display("FAIL lw_stall: got %0d expected 4", obsStall); end
      nChecks++; if (obsReq !== 1 || obsAddr !== 32'h100) begin nFails++;
         $display("FAIL lw_req: got n=%0d a=%h expected 1 100", obsReq, obsAddr); end
      nChecks++; if (obsFwdCnt !== 1 || obsFwdCycle !== 5) begin nFails++;
         $display("FAIL lw_fwd_timing: got n=%0d c=%0d expected 1 5", obsFwdCnt, obsFwdCycle); end
      nChecks++; if (obsFwdRd !== 5'd5 || obsFwdData !== 32'hDEADBEEF) begin nFails++;
         $display("FAIL lw_fwd_value: got rd=%0d d=%h expected 5 deadbeef", obsFwdRd, obsFwdData); end
      lastData = 32'hDEADBEEF; lastRd = 5'd5;
   endtask

   task automatic test_extract();
      logic [2:0]  f3s [3];
      logic [31:0] addrs [3];
      logic [31:0] exps [3];
      f3s[0] = 3'd0; addrs[0] = 32'h203; exps[0] = 32'hFFFFFF80;
      f3s[1] = 3'd4; addrs[1] = 32'h203; exps[1] = 32'h00000080;
      f3s[2] = 3'd5; addrs[2] = 32'h202; exps[2] = 32'h00008011;
      for (int i = 0; i < 3; i++) begin
         runLoad(f3s[i], 5'd9, addrs[i], 1, 32'h80112233, 1'b0);
         nChecks++; if (obsFwdCnt !== 1 || obsFwdData !== exps[i]) begin nFails++;
            $display("FAIL extract_%0d: got n=%0d d=%h expected 1 %h", i, obsFwdCnt, obsFwdData, exps[i]); end
         lastData = exps[i]; lastRd = 5'd9;
      end
   endtask

   task automatic test_rd_zero();
      runLoad(3'd2, 5'd0, 32'h0000_0300, 3, 32'h12345678, 1'b0);
      nChecks++; if (obsReq !== 1 || obsStall !== 4) begin nFails++;
         $display("FAIL rd0_handshake: got req=%0d stall=%0d expected 1 4", obsReq, obsStall); end
      nChecks++; if (obsFwdCnt !== 0) begin nFails++; $display("FAIL rd0_fwd: got %0d expected 0", obsFwdCnt); end
      nChecks++; if (obsFinalData !== lastData || obsFinalRd !== lastRd) begin nFails++;
         $display("FAIL rd0_hold: got rd=%0d d=%h expected %0d %h", obsFinalRd, obsFinalData, lastRd, lastData); end
   endtask

   task automatic test_timeout();
      // delay TO-1: rvalid in the last WAIT cycle still completes
      runLoad(3'd2, 5'd4, 32'h0000_0500, TO - 1, 32'hA5A5_0001, 1'b0);
      nChecks++; if (obsErrCnt !== 0 || obsFwdCnt !== 1 || obsFwdData !== 32'hA5A5_0001) begin nFails++;
         $display("FAIL timeout_edge_ok: got err=%0d fwd=%0d d=%h expected 0 1 a5a50001", obsErrCnt, obsFwdCnt, obsFwdData); end
      lastData = 32'hA5A5_0001; lastRd = 5'd4;
      // delay TO: rvalid arrives one cycle too late
      runLoad(3'd2, 5'd6, 32'h0000_0600, TO, 32'h1111_2222, 1'b0);
      nChecks++; if (obsErrCnt !== 1 || obsErrCycle !== TO + 1) begin nFails++;
         $display("FAIL timeout_err: got n=%0d c=%0d expected 1 %0d", obsErrCnt, obsErrCycle, TO + 1); end
      nChecks++; if (obsStall !== TO + 1) begin nFails++; $display("FAIL timeout_stall: got %0d expected %0d", obsStall, TO + 1); end
      nChecks++; if (obsFwdCnt !== 0 || obsFinalData !== lastData) begin nFails++;
         $display("FAIL timeout_fwd: got n=%0d d=%h expected 0 %h", obsFwdCnt, obsFinalData, lastData); end
   endtask

   task automatic test_reset_in_wait();
      int sawFwd = 0;
      int sawStall = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         m_valid     = (c == 0);
         inst_M      = (c == 0) ? {17'd0, 3'd2, 5'd7, 7'b0000011} : 32'd0;
         addr_M      = 32'h40;
         rst_n       = !(c == 2);
         dmem_rvalid = (c == 4);
         dmem_rdata  = 32'hCAFE_F00D;
         #1;
         if (c == 2) begin
            nChecks++; if ({dmem_req, stall, fwd_valid, load_err, fwd_rd, fwd_data} !== 41'd0) begin nFails++;
               $display("FAIL rstwait_outs: got req=%b st=%b v=%b e=%b rd=%0d d=%h expected all 0",
                        dmem_req, stall, fwd_valid, load_err, fwd_rd, fwd_data); end
         end
         if (c > 2 && fwd_valid) sawFwd++;
         if (c > 2 && stall) sawStall++;
      end
      nChecks++; if (sawFwd !== 0 || sawStall !== 0) begin nFails++;
         $display("FAIL rstwait_after: got fwd=%0d stall=%0d expected 0 0", sawFwd, sawStall); end
      dmem_rvalid = 1'b0;
      lastData = 32'd0; lastRd = 5'd0;
   endtask

   task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
      int errs = 0;
      int reqs = 0;
      int stalls = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         m_valid = (c == 0);
         inst_M  = (c == 0) ? {17'd0, 3'd1, 5'd8, 7'b0000011} : 32'd0;
         addr_M  = 32'h101;
         dmem_rvalid = (c == 2);
         #1;
         if (dmem_req) reqs++;
         if (stall) stalls++;
         if (load_err) begin
            errs++;
            nChecks++; if (c !== 1) begin nFails++; $display("FAIL misalign_err_cycle: got %0d expected 1", c); end
         end
      end
      nChecks++; if (errs !== 1 || reqs !== 0 || stalls !== 0) begin nFails++;
         $display("FAIL misalign_trap: got err=%0d req=%0d stall=%0d expected 1 0 0", errs, reqs, stalls); end
`else
      runLoad(3'd1, 5'd8, 32'h101, 2, 32'h1234_F00D, 1'b0);
      nChecks++; if (obsReq !== 1 || obsAddr !== 32'h100 || obsErrCnt !== 0) begin nFails++;
         $display("FAIL misalign_req: got n=%0d a=%h e=%0d expected 1 100 0", obsReq, obsAddr, obsErrCnt); end
      nChecks++; if (obsFwdData !== 32'hFFFF_F00D) begin nFails++;
         $display("FAIL misalign_data: got %h expected fffff00d", obsFwdData); end
      lastData = 32'hFFFF_F00D; lastRd = 5'd8;
`endif
   endtask

   task automatic test_non_load();
      int bad = 0;
      logic [6:0] opc;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         opc = 7'($urandom());
         if (opc == 7'b0000011) opc = 7'b0110011;
         m_valid = 1'b1; inst_M = {$urandom()} & 32'hFFFF_FF80 | {25'd0, opc};
         addr_M = $urandom(); dmem_rvalid = 1'($urandom()); dmem_rdata = $urandom();
         #1;
         if (dmem_req || stall || fwd_valid || load_err) bad++;
      end
      m_valid = 1'b0; dmem_rvalid = 1'b0;
      nChecks++; if (bad !== 0) begin nFails++; $display("FAIL nonload_quiet: got %0d active cycles expected 0", bad); end
      nChecks++; if (fwd_data !== lastData || fwd_rd !== lastRd) begin nFails++;
         $display("FAIL nonload_hold: got rd=%0d d=%h expected %0d %h", fwd_rd, fwd_data, lastRd, lastData); end
   endtask

   task automatic test_random();
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic [31:0] addr, data, expD;
      int delay, expStall;
      logic tmo;
      for (int n = 0; n < 40; n++) begin
         f3 = 3'($urandom()); rd = 5'($urandom_range(0, 31));
         if (n % 7 == 0) rd = 5'd0;
         addr = $urandom(); data = $urandom();
`ifdef MISALIGN_TRAP_EN
         if (f3 == 3'd1 || f3 == 3'd5) addr[0] = 1'b0;
         if (f3 == 3'd2) addr[1:0] = 2'b00;
`endif
         delay = (n % 9 == 0) ? $urandom_range(TO, TO + 3) : $urandom_range(0, TO - 1);
         runLoad(f3, rd, addr, delay, data, 1'($urandom()));
         tmo = (delay >= TO);
         expStall = tmo ? TO + 1 : delay + 1;
         nChecks++; if (obsReq !== 1 || obsAddr !== (addr & 32'hFFFF_FFFC) || obsStall !== expStall) begin nFails++;
            $display("FAIL rand_%0d_hs: got req=%0d a=%h st=%0d expected 1 %h %0d", n, obsReq, obsAddr, obsStall,
                     addr & 32'hFFFF_FFFC, expStall); end
         nChecks++; if (obsErrCnt !== (tmo ? 1 : 0)) begin nFails++;
            $display("FAIL rand_%0d_err: got %0d expected %0d", n, obsErrCnt, tmo ? 1 : 0); end
         if (!tmo && rd != 5'd0) begin
            expD = refLoad(f3, addr, data);
            nChecks++; if (obsFwdCnt !== 1 || obsFwdCycle !== delay + 2 || obsFwdRd !== rd || obsFwdData !== expD) begin nFails++;
               $display("FAIL rand_%0d_fwd: got n=%0d c=%0d rd=%0d d=%h expected 1 %0d %0d %h", n, obsFwdCnt,
                        obsFwdCycle, obsFwdRd, obsFwdData, delay + 2, rd, expD); end
            lastData = expD; lastRd = rd;
         end else begin
            nChecks++; if (obsFwdCnt !== 0) begin nFails++; $display("FAIL rand_%0d_nofwd: got %0d expected 0", n, obsFwdCnt); end
         end
         nChecks++; if (obsFinalData !== lastData || obsFinalRd !== lastRd) begin nFails++;
            $display("FAIL rand_%0d_hold: got rd=%0d d=%h expected %0d %h", n, obsFinalRd, obsFinalData, lastRd, lastData); end
      end
   endtask

   initial begin
      test_reset();
      test_lw_basic();
      test_extract();
      test_rd_zero();
      test_timeout();
      test_non_load();
      test_reset_in_wait();
      test_misalign();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/mem_fwd_ctrl.md
MEM_FWD_CTRL -- requirements
Module: mem_fwd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: maximum WAIT cycles before a load is aborted (range 2..255).
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port m_valid, input, 1: a new instruction is presented in the M stage this cycle (one pulse per instruction).
REQ-005 SHALL have port inst_M, input, 32: M-stage instruction (opcode [6:0], rd [11:7], funct3 [14:12]).
REQ-006 SHALL have port addr_M, input, 32: effective load address computed in X.
REQ-007 SHALL have port dmem_req, output, 1: data-memory read request.
REQ-008 SHALL have port dmem_addr, output, 32: word-aligned request address {addr_M[31:2],2'b00}.
REQ-009 SHALL have port dmem_rvalid, input, 1: read data valid.
REQ-010 SHALL have port dmem_rdata, input, 32: raw read word.
REQ-011 SHALL have port stall, output, 1: freezes the IF/X/M pipeline registers.
REQ-012 SHALL have port fwd_valid, output, 1: fwd_data/fwd_rd are valid for X-stage MEM forwarding and writeback.
REQ-013 SHALL have port fwd_rd, output, 5: destination register of the completed load.
REQ-014 SHALL have port fwd_data, output, 32: extracted, extended load result.
REQ-015 SHALL have port load_err, output, 1: one-cycle pulse on timeout or misalignment trap.

Function
REQ-016 SHALL implement states IDLE, WAIT, DONE; only IDLE accepts a new load.
REQ-017 In IDLE with m_valid=1 and inst_M[6:0]=OPC_LOAD, SHALL assert dmem_req and stall combinationally in that cycle, latch rd/funct3/addr_M[1:0], and enter WAIT.
REQ-018 In IDLE, non-load instructions SHALL leave dmem_req=0 and stall=0.
REQ-019 In WAIT, stall SHALL equal ~dmem_rvalid; dmem_req SHALL be 0.
REQ-020 On dmem_rvalid in WAIT, SHALL register the extracted result and enter DONE; in DONE, fwd_valid=1 for exactly one cycle, then return to IDLE.
REQ-021 Extraction by latched funct3/offset: LB/LBU select byte offset and sign-/zero-extend; LH/LHU select halfword offset[1] and sign-/zero-extend; LW passes the word; reserved funct3 values 3,6,7 SHALL yield fwd_data=0.
REQ-022 When latched rd=x0, the full transaction SHALL run but fwd_valid SHALL stay 0.
REQ-023 A WAIT cycle counter SHALL clear on WAIT entry; if it reaches TIMEOUT_CYCLES without rvalid, SHALL pulse load_err, drop stall, and return to IDLE with fwd_valid=0.
REQ-024 dmem_rvalid received in IDLE or DONE SHALL be ignored.
REQ-025 fwd_data and fwd_rd SHALL hold their last values when fwd_valid=0.

Reset
REQ-026 rst_n=0 SHALL asynchronously force IDLE, counter=0, fwd_valid=0, load_err=0, fwd_rd=0, fwd_data=0; dmem_req=0 and stall=0 while in reset.
REQ-027 Reset asserted in WAIT SHALL abandon the transaction; a later rvalid SHALL produce no fwd_valid.

Configuration
REQ-028 Macro MISALIGN_TRAP_EN defined: a LH/LHU with addr_M[0]=1 or LW with addr_M[1:0]!=0 in IDLE SHALL issue no request, pulse load_err, keep stall=0, and remain in IDLE.
REQ-029 Macro MISALIGN_TRAP_EN undefined: misaligned loads SHALL proceed, ignoring addr_M[0] for halfwords and addr_M[1:0] for words; load_err SHALL then come only from timeout.

Verification
REQ-030 LW rd=x5, addr 0x100, rvalid 3 cycles later with 0xDEADBEEF -> stall high 4 cycles, dmem_addr=0x100, then fwd_valid=1, fwd_rd=5, fwd_data=0xDEADBEEF for one cycle.
REQ-031 LB addr 0x203, rdata 0x80112233 -> fwd_data=0xFFFFFF80; LBU at the same address -> 0x00000080; LHU addr 0x202 -> 0x00008011.
REQ-032 LW rd=x0 -> dmem_req pulses and stall behaves per REQ-030, fwd_valid never 1.
REQ-033 LW with no rvalid -> load_err pulse after 16 WAIT cycles, stall low, state IDLE; a late rvalid is ignored.
REQ-034 rst_n low in the 2nd WAIT cycle, rvalid 2 cycles later -> outputs zero, no fwd_valid.
REQ-035 With MISALIGN_TRAP_EN, LH addr 0x101 -> load_err=1, dmem_req=0, stall=0; without it -> request to 0x100, fwd_data from halfword [15:0].
